// File: rtl/pipe_score_keeper.sv
// Pipe-pass scorer: awards one point per pillar passing the bird through its gap,
// keeps a saturating BCD score, a restart-surviving high score and 7-segment output.
module pipe_score_keeper #(
  parameter int unsigned NUM_PILLARS = 3,
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned SCORE_X     = 14,
  parameter int unsigned GAP_H       = 36
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       game_reset,
  input  logic                       enable,
  input  logic [NUM_PILLARS*X_W-1:0] pillar_x,
  input  logic [NUM_PILLARS*Y_W-1:0] gap_y,
  input  logic [Y_W-1:0]             bird_y,
  output logic [DIGITS*4-1:0]        score_bcd,
  output logic [DIGITS*4-1:0]        high_bcd,
  output logic [DIGITS*7-1:0]        seg_score,
  output logic                       score_pulse,
  output logic                       new_high,
  output logic                       saturated
);

  localparam int unsigned SW = DIGITS * 4;

  logic [NUM_PILLARS-1:0] armed, armed_next, at_x, in_gap, cand, win;
  logic                   award;
  logic [SW-1:0]          score_inc;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0001100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Gap bounds are widened by one bit so gap_y + GAP_H cannot wrap.
  always_comb begin
    at_x   = '0;
    in_gap = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_PILLARS; i++) begin : g_pillar
      logic [Y_W:0] lo;
      logic [Y_W:0] hi;
      logic [Y_W:0] by;
      lo = {1'b0, gap_y[i*Y_W +: Y_W]} + (Y_W+1)'(1);
      hi = {1'b0, gap_y[i*Y_W +: Y_W]} + (Y_W+1)'(GAP_H);
      by = {1'b0, bird_y};
      in_gap[i] = (lo <= by) && (by <= hi);
      at_x[i]   = pillar_x[i*X_W +: X_W] == X_W'(SCORE_X);
      cand[i]   = enable && armed[i] && at_x[i] && in_gap[i];
    end
  end

  always_comb begin
    win   = '0;
    award = 1'b0;
    for (int unsigned i = 0; i < NUM_PILLARS; i++) begin
      if (cand[i] && !award) begin
        win[i] = 1'b1;
        award  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_PILLARS; i++) begin
      if (!at_x[i])        armed_next[i] = 1'b1;
      else if (!in_gap[i]) armed_next[i] = 1'b0;
      else if (win[i])     armed_next[i] = 1'b0;
      else                 armed_next[i] = armed[i];
    end
  end

  always_comb begin
    saturated = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (score_bcd[d*4 +: 4] != 4'd9) saturated = 1'b0;
    end
  end

  // Ripple BCD increment; a saturated score is held instead of wrapping.
  always_comb begin
    logic carry;
    score_inc = score_bcd;
    carry     = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (score_inc[d*4 +: 4] == 4'd9) begin
          score_inc[d*4 +: 4] = 4'd0;
        end else begin
          score_inc[d*4 +: 4] = score_inc[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (saturated) score_inc = score_bcd;
  end

  always_comb begin
    seg_score = '1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      seg_score[d*7 +: 7] = seg7(score_bcd[d*4 +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      score_bcd   <= '0;
      high_bcd    <= '0;
      armed       <= '0;
      score_pulse <= 1'b0;
      new_high    <= 1'b0;
    end else if (!game_reset) begin
      score_bcd   <= '0;
      armed       <= '0;
      score_pulse <= 1'b0;
      new_high    <= 1'b0;
    end else begin
      armed       <= armed_next;
      score_pulse <= award;
      new_high    <= 1'b0;
      if (award) begin
        score_bcd <= score_inc;
        if (score_inc > high_bcd) begin
          high_bcd <= score_inc;
          new_high <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_score_keeper.sv
// Directed self-checking bench for pipe_score_keeper with hand-computed expectations.
module tb_pipe_score_keeper;

  logic        clk = 1'b0;
  logic        reset_n, game_reset, enable;
  logic [23:0] pillar_x;
  logic [20:0] gap_y;
  logic [6:0]  bird_y;
  logic [7:0]  score_bcd, high_bcd;
  logic [13:0] seg_score;
  logic        score_pulse, new_high, saturated;

  logic [7:0] px [3];
  logic [6:0] gy [3];
  int checks = 0;
  int errors = 0;
  int nh_count;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pillar_x[i*8 +: 8] = px[i];
      gap_y[i*7 +: 7]    = gy[i];
    end
  end

  pipe_score_keeper #(
    .NUM_PILLARS(3), .X_W(8), .Y_W(7), .DIGITS(2), .SCORE_X(14), .GAP_H(36)
  ) dut (
    .clk(clk), .reset_n(reset_n), .game_reset(game_reset), .enable(enable),
    .pillar_x(pillar_x), .gap_y(gap_y), .bird_y(bird_y),
    .score_bcd(score_bcd), .high_bcd(high_bcd), .seg_score(seg_score),
    .score_pulse(score_pulse), .new_high(new_high), .saturated(saturated)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full pass of pillar 0: leave SCORE_X to arm, then arrive at it.
  task automatic pass0();
    px[0] = 8'd13;
    step();
    px[0] = 8'd14;
    step();
  endtask

  initial begin
    reset_n = 1'b0; game_reset = 1'b1; enable = 1'b1;
    px[0] = 8'd50; px[1] = 8'd60; px[2] = 8'd70;
    gy[0] = 7'd10; gy[1] = 7'd10; gy[2] = 7'd10;
    bird_y = 7'd30;
    step(); step();
    check("rst_score", score_bcd, 8'h00);
    check("rst_high", high_bcd, 8'h00);
    check("rst_pulse", score_pulse, 1'b0);
    check("rst_newhigh", new_high, 1'b0);
    check("rst_sat", saturated, 1'b0);
    check("rst_seg", seg_score, 14'b0000001_0000001);

    reset_n = 1'b1;
    px[0] = 8'd20; step();
    px[0] = 8'd14; step();
    check("pass1_score", score_bcd, 8'h01);
    check("pass1_pulse", score_pulse, 1'b1);
    check("pass1_high", high_bcd, 8'h01);
    check("pass1_newhigh", new_high, 1'b1);
    check("pass1_seg0", seg_score[6:0], 7'b1001111);
    check("pass1_seg1", seg_score[13:7], 7'b0000001);

    step();
    check("dwell_pulse", score_pulse, 1'b0);
    check("dwell_newhigh", new_high, 1'b0);
    repeat (3) step();
    check("dwell_score", score_bcd, 8'h01);
    pass0();
    check("rearm_score", score_bcd, 8'h02);
    check("rearm_pulse", score_pulse, 1'b1);
    check("rearm_high", high_bcd, 8'h02);

    px[0] = 8'd13; step();
    bird_y = 7'd10; px[0] = 8'd14; step();
    check("outgap_pulse", score_pulse, 1'b0);
    bird_y = 7'd30; step();
    check("forfeit_pulse", score_pulse, 1'b0);
    check("forfeit_score", score_bcd, 8'h02);

    bird_y = 7'd47; pass0();
    check("bird47_pulse", score_pulse, 1'b0);
    bird_y = 7'd46; pass0();
    check("bird46_pulse", score_pulse, 1'b1);
    check("bird46_score", score_bcd, 8'h03);

    bird_y = 7'd30;
    px[0] = 8'd13; px[2] = 8'd13; step();
    px[0] = 8'd14; px[2] = 8'd14; step();
    check("simul_n_score", score_bcd, 8'h04);
    step();
    check("simul_n1_score", score_bcd, 8'h05);
    check("simul_n1_pulse", score_pulse, 1'b1);
    step();
    check("simul_n2_pulse", score_pulse, 1'b0);
    px[2] = 8'd70;

    game_reset = 1'b0; step();
    check("grst_score", score_bcd, 8'h00);
    check("grst_high", high_bcd, 8'h05);
    check("grst_pulse", score_pulse, 1'b0);
    game_reset = 1'b1;
    nh_count = 0;
    for (int k = 0; k < 3; k++) begin
      pass0();
      if (new_high) nh_count++;
    end
    check("restart3_score", score_bcd, 8'h03);
    check("restart3_high", high_bcd, 8'h05);
    check("restart3_nh", nh_count, 0);
    for (int k = 0; k < 3; k++) begin
      pass0();
      if (new_high) nh_count++;
    end
    check("restart6_high", high_bcd, 8'h06);
    check("restart6_nh", nh_count, 1);

    repeat (3) pass0();
    check("nine_score", score_bcd, 8'h09);
    check("nine_seg0", seg_score[6:0], 7'b0001100);
    pass0();
    check("carry_score", score_bcd, 8'h10);
    check("carry_seg", seg_score, 14'b1001111_0000001);
    check("carry_sat", saturated, 1'b0);

    enable = 1'b0; pass0();
    check("dis_pulse", score_pulse, 1'b0);
    check("dis_score", score_bcd, 8'h10);
    enable = 1'b1; step();
    check("reen_pulse", score_pulse, 1'b1);
    check("reen_score", score_bcd, 8'h11);

    repeat (88) pass0();
    check("sat_score", score_bcd, 8'h99);
    check("sat_flag", saturated, 1'b1);
    check("sat_high", high_bcd, 8'h99);
    pass0();
    check("satpass_score", score_bcd, 8'h99);
    check("satpass_pulse", score_pulse, 1'b1);
    check("satpass_flag", saturated, 1'b1);
    check("satpass_nh", new_high, 1'b0);

    gy[0] = 7'd120; bird_y = 7'd120; pass0();
    check("gap120_bird120", score_pulse, 1'b0);
    bird_y = 7'd121; pass0();
    check("gap120_bird121", score_pulse, 1'b1);

    reset_n = 1'b0; step();
    check("rst2_score", score_bcd, 8'h00);
    check("rst2_high", high_bcd, 8'h00);
    check("rst2_sat", saturated, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_score_keeper.md
Name: pipe_score_keeper

Overview:
- Parametrised successor to the fixed three-pillar, two-digit scorer.
- Watches NUM_PILLARS pillars and awards exactly one point per pillar pass through the gap.
- Holds the current score as a DIGITS-wide BCD counter that saturates at its maximum, and retains a high score across game restarts.
- Drives active-low 7-segment patterns for the display path. Sits between the pillar/bird position logic and the HEX display drivers.

Parameters:
- NUM_PILLARS, 3: number of pillar channels.
- X_W, 8: pillar x-coordinate width.
- Y_W, 7: bird/gap y-coordinate width.
- DIGITS, 2: number of BCD score digits.
- SCORE_X, 14: pillar x at which a pass is evaluated.
- GAP_H, 36: gap height in pixels.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: synchronous, active-low reset; clock clk.
- game_reset, input, 1: synchronous, active-low; clears the current score only.
- enable, input, 1: scoring enable (game running).
- pillar_x, input, NUM_PILLARS*X_W: packed pillar x; pillar i at [i*X_W +: X_W].
- gap_y, input, NUM_PILLARS*Y_W: packed gap top y; gap i at [i*Y_W +: Y_W].
- bird_y, input, Y_W: bird y.
- score_bcd, output, DIGITS*4: current score; digit 0 (ones) at [3:0].
- high_bcd, output, DIGITS*4: high score, same packing as score_bcd.
- seg_score, output, DIGITS*7: active-low segments of score_bcd; digit d at [d*7 +: 7].
- score_pulse, output, 1: one-cycle pulse on each point awarded.
- new_high, output, 1: one-cycle pulse when high_bcd is updated.
- saturated, output, 1: high while score_bcd is all 9s.

Behaviour:
- Priority per edge: reset_n low, then game_reset low, then normal operation.
- reset_n low:
  - score_bcd=0, high_bcd=0, all armed[i]=0.
  - score_pulse=0, new_high=0, saturated=0.
- game_reset low (reset_n high):
  - score_bcd=0, armed[i]=0, score_pulse=0, new_high=0.
  - high_bcd is held.
- Gap test for pillar i: in_gap_i = (gap_y_i + 1 <= bird_y) && (bird_y <= gap_y_i + GAP_H).
  - Both sums are computed in Y_W+1 bits, so there is no wrap-around.
- Arming:
  - Every cycle outside reset, armed[i] <= 1 if pillar_x_i != SCORE_X.
  - Arming runs regardless of enable.
  - A pillar sitting at SCORE_X at reset therefore cannot score until it has left SCORE_X.
- Candidate: cand_i = enable && armed[i] && pillar_x_i == SCORE_X && in_gap_i.
- Per cycle:
  - At most one point is awarded, to the lowest-index cand_i. That pillar gets armed[i] <= 0.
  - Other candidates keep armed=1 and are evaluated again next cycle.
  - A pillar at SCORE_X that is not in the gap gets armed[i] <= 0 (pass forfeited, no point).
- Increment:
  - BCD ripple increment; digit d rolls 9 to 0 and carries into d+1.
  - If score_bcd is all 9s, the score is held (no wrap).
  - score_pulse still asserts on an awarded pass while saturated; saturated stays 1.
- Latency:
  - Inputs are sampled at edge N. score_bcd, score_pulse, high_bcd and new_high are valid after edge N.
  - score_pulse is high for exactly one cycle per award.
- High score:
  - On the award edge, if the incremented score > high_bcd, high_bcd is set to the incremented score and new_high pulses in the same cycle as score_pulse.
  - Compare the packed BCD as unsigned binary, which is numerically equivalent.
  - Equality does not update high_bcd.
- saturated is combinational from score_bcd.
- seg_score:
  - Combinational, per digit: bit6=a ... bit0=g, active-low.
  - Encodings: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
  - Any non-BCD nibble displays 1111111 (blank).
  - No latches: full case with default.
- enable low: no awards and no pulses; the score is held.

Test Plan:
- Reset then pass: reset_n low 2 cycles; pillar0 x=20, then 14 with gap_y=10, bird_y=30, enable=1 → score_bcd=0x01, score_pulse one cycle, high_bcd=0x01, new_high=1, seg_score[6:0]=1001111.
- Dwell and re-arm: pillar0 held at x=14 for 5 cycles → exactly 1 point. Move to x=13, then back to 14 → score=0x02.
- Out of gap: gap_y=10, bird_y=10 at x=14 → no point; bird then moves into the gap while still at x=14 → still no point (forfeited). bird_y=47 fails the gap test; bird_y=46 passes.
- Simultaneous pillars: pillar0 and pillar2 both at x=14 in gap → score +1 in cycle N, +1 again in N+1 (pillar2), total +2.
- Carry and saturate:
  - Preload to 0x09 via passes, one more → 0x10.
  - Drive to 0x99 → saturated=1; a further pass keeps 0x99 with score_pulse=1.
  - Boundary: gap_y=120, bird_y=121 passes with no 7-bit wrap error.
- Restart keeps high: after score 0x05, game_reset low 1 cycle → score=0x00, high_bcd=0x05. Three passes → high stays 0x05 with no new_high; six passes → high=0x06, new_high pulses once.
